pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, 17, width of PC, branch target and memory address.
REQ-002 Parameter TIMEOUT, 15, max WAIT cycles before fault (1..255).
REQ-003 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-004 Clock  input  1  single clock; all state on rising edge.
REQ-005 ResetN  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  begin fetching from current PC; honoured in IDLE only.
REQ-007 Halt  input  1  stop after current instruction completes.
REQ-008 MemAck  input  1  instruction memory accepts/returns current request.
REQ-009 InstrWide  input  1  valid with MemAck; 1 = 4-byte instruction, 0 = 2-byte.
REQ-010 BranchTaken  input  1  valid with MemAck; next PC = BranchTarget.
REQ-011 BranchTarget  input  WIDTH  branch destination, sampled with MemAck.
REQ-012 MemReq  output  1  fetch request to instruction memory.
REQ-013 MemAddr  output  WIDTH  fetch address; equals PC.
REQ-014 Selection  output  2  next-PC mux select: 0 = BranchTarget, 1 = +2, 2 = +4; 3 never driven.
REQ-015 PC  output  WIDTH  current program counter.
REQ-016 Running  output  1  high in FETCH, WAIT, ADVANCE.
REQ-017 Fault  output  1  sticky error flag; high in FAULT.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, WAIT, ADVANCE, FAULT.
REQ-019 IDLE: MemReq=0; Start=1 -> FETCH next cycle; else stay.
REQ-020 FETCH: MemReq=1, MemAddr=PC; -> WAIT unconditionally; wait counter cleared.
REQ-021 WAIT: MemReq held 1, MemAddr stable; MemAck=1 -> ADVANCE, latching InstrWide, BranchTaken, BranchTarget.
REQ-022 WAIT without MemAck: counter +1 per cycle; counter reaching TIMEOUT -> FAULT; MemAck in the cycle the count reaches TIMEOUT takes priority (-> ADVANCE).
REQ-023 Selection SHALL be registered in WAIT on MemAck: BranchTaken -> 0; else InstrWide -> 2; else 1; holds value otherwise.
REQ-024 ADVANCE: PC updated once per instruction: BranchTarget, PC+2 or PC+4 per Selection; sum modulo 2^WIDTH (0x1FFFE+2 -> 0x00000, 0x1FFFE+4 -> 0x00002).
REQ-025 ADVANCE: Halt=1 -> IDLE; else -> FETCH. Latency Ack-to-next-MemReq = 2 cycles.
REQ-026 Latched BranchTarget with bit0=1 SHALL -> FAULT from ADVANCE; PC not updated.
REQ-027 FAULT: MemReq=0, Fault=1, PC frozen; exited only by reset; Start ignored.
REQ-028 Halt outside ADVANCE SHALL be ignored; Start outside IDLE ignored.
REQ-029 MemAck outside WAIT SHALL be ignored, no state change.
REQ-030 At most one outstanding request; MemReq never deasserted in WAIT before MemAck.

Reset
REQ-031 ResetN=0 SHALL immediately force IDLE, PC=RESET_PC, MemReq=0, Selection=1, Running=0, Fault=0, counter=0, regardless of state (incl. mid-WAIT).
REQ-032 First FETCH after ResetN release requires Start; no request issued on release alone.

Verification
REQ-033 Reset, Start, MemAck after 3 cycles, InstrWide=0 -> Selection=1, PC 0x00000 -> 0x00002, MemReq re-asserted 2 cycles after Ack.
REQ-034 PC=0x1FFFC, two Acks InstrWide=1 -> PC 0x00000 then 0x00004, Selection=2.
REQ-035 Ack with BranchTaken=1, BranchTarget=0x00100 -> Selection=0, PC=0x00100; BranchTarget=0x00101 -> Fault=1, PC unchanged, MemReq=0.
REQ-036 TIMEOUT=15, no MemAck -> FAULT entered after 15 WAIT cycles; Ack at count 15 -> ADVANCE instead.
REQ-037 Halt=1 during ADVANCE -> IDLE, MemReq=0; Start -> fetch resumes at updated PC.
REQ-038 ResetN pulsed low mid-WAIT -> MemReq drops asynchronously, PC=RESET_PC, Fault=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues one instruction fetch at a time, waits for the
// memory acknowledge, then advances the PC by 2, by 4 or to a branch target.
module pc_sequencer #(
    parameter int unsigned      WIDTH    = 17,
    parameter int unsigned      TIMEOUT  = 15,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(0)
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic             Halt,
    input  logic             MemAck,
    input  logic             InstrWide,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    output logic             MemReq,
    output logic [WIDTH-1:0] MemAddr,
    output logic [1:0]       Selection,
    output logic [WIDTH-1:0] PC,
    output logic             Running,
    output logic             Fault
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] SEL_BRANCH = 2'd0;
    localparam logic [1:0] SEL_INC2   = 2'd1;
    localparam logic [1:0] SEL_INC4   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [WIDTH-1:0]   target_q;
    logic [WIDTH-1:0]   pc_next_c;
    logic               misaligned_c;
    logic [1:0]         sel_on_ack_c;

    // The fetch address is always the current PC, which only moves in ADVANCE.
    assign MemAddr = PC;

    // Next-PC mux driven by the select captured with the acknowledge.
    always_comb begin
        pc_next_c = PC;
        case (Selection)
            SEL_BRANCH: pc_next_c = target_q;
            SEL_INC4:   pc_next_c = PC + WIDTH'(4);
            default:    pc_next_c = PC + WIDTH'(2);
        endcase
    end

    // A taken branch to an odd address cannot be a legal instruction boundary.
    assign misaligned_c = (Selection == SEL_BRANCH) && target_q[0];

    always_comb begin
        sel_on_ack_c = SEL_INC2;
        if (BranchTaken) begin
            sel_on_ack_c = SEL_BRANCH;
        end else if (InstrWide) begin
            sel_on_ack_c = SEL_INC4;
        end
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= S_IDLE;
            PC        <= RESET_PC;
            MemReq    <= 1'b0;
            Selection <= SEL_INC2;
            Running   <= 1'b0;
            Fault     <= 1'b0;
            wait_cnt  <= '0;
            target_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state   <= S_FETCH;
                        MemReq  <= 1'b1;
                        Running <= 1'b1;
                    end
                end

                S_FETCH: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end

                S_WAIT: begin
                    // An acknowledge wins over a timeout landing in the same cycle.
                    if (MemAck) begin
                        state     <= S_ADVANCE;
                        MemReq    <= 1'b0;
                        Selection <= sel_on_ack_c;
                        target_q  <= BranchTarget;
                    end else if (wait_cnt == CNT_LAST) begin
                        state    <= S_FAULT;
                        MemReq   <= 1'b0;
                        Running  <= 1'b0;
                        Fault    <= 1'b1;
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_ADVANCE: begin
                    if (misaligned_c) begin
                        state   <= S_FAULT;
                        Running <= 1'b0;
                        Fault   <= 1'b1;
                    end else begin
                        PC <= pc_next_c;
                        if (Halt) begin
                            state   <= S_IDLE;
                            Running <= 1'b0;
                        end else begin
                            state  <= S_FETCH;
                            MemReq <= 1'b1;
                        end
                    end
                end

                S_FAULT: begin
                    state <= S_FAULT;
                end

                default: begin
                    state   <= S_IDLE;
                    MemReq  <= 1'b0;
                    Running <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the registered outputs.
    a_sel_legal: assert property (@(posedge Clock) disable iff (!ResetN)
        Selection != 2'd3);

    a_req_running: assert property (@(posedge Clock) disable iff (!ResetN)
        MemReq |-> Running);

    a_fault_idle: assert property (@(posedge Clock) disable iff (!ResetN)
        Fault |-> (!Running && !MemReq));

    a_req_held: assert property (@(posedge Clock) disable iff (!ResetN)
        (state == S_WAIT && !MemAck && wait_cnt != CNT_LAST) |=> MemReq);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: expected fetch addresses are queued when an
// instruction is acknowledged and popped when the DUT raises its next request.
module tb_pc_sequencer;

    localparam int unsigned W = 17;

    logic         Clock = 1'b0;
    logic         ResetN = 1'b0;
    logic         Start = 1'b0;
    logic         Halt = 1'b0;
    logic         MemAck = 1'b0;
    logic         InstrWide = 1'b0;
    logic         BranchTaken = 1'b0;
    logic [W-1:0] BranchTarget = '0;
    logic         MemReq;
    logic [W-1:0] MemAddr;
    logic [1:0]   Selection;
    logic [W-1:0] PC;
    logic         Running;
    logic         Fault;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    int unsigned  exp_pc = 0;
    int unsigned  sb_q[$];
    logic         req_prev = 1'b0;

    pc_sequencer #(.WIDTH(17), .TIMEOUT(15), .RESET_PC(17'h00000)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .Halt(Halt),
        .MemAck(MemAck), .InstrWide(InstrWide), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .MemReq(MemReq), .MemAddr(MemAddr),
        .Selection(Selection), .PC(PC), .Running(Running), .Fault(Fault)
    );

    initial forever #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Every rising MemReq must match the next queued fetch address.
    always @(negedge Clock) begin
        if (ResetN && MemReq && !req_prev) begin
            if (sb_q.size() == 0) check("sb_unexpected_req", 32'(MemReq), 32'd0);
            else check("sb_fetch_addr", 32'(MemAddr), sb_q.pop_front());
        end
        req_prev = MemReq;
    end

    task automatic start_fetch();
        sb_q.push_back(exp_pc);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("start_req", 32'(MemReq), 32'd1);
        check("start_running", 32'(Running), 32'd1);
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        step();
        step();
        ResetN = 1'b1;
        exp_pc = 0;
        sb_q.delete();
    endtask

    // One fetch: optional stray ack in FETCH, `delay` silent WAIT cycles, then the ack.
    task automatic do_instr(input int delay, input bit wide, input bit taken,
                            input logic [W-1:0] tgt, input bit halt, input bit early_ack);
        int n;
        bit misalign;
        logic [1:0] sel;
        int unsigned nxt;
        n = 0;
        while (!MemReq && n < 40) begin
            step();
            n++;
        end
        check("req_seen", 32'(MemReq), 32'd1);
        if (early_ack) begin
            MemAck = 1'b1; InstrWide = 1'b1; BranchTaken = 1'b1; BranchTarget = 17'h00AAA;
        end
        step();
        MemAck = 1'b0; InstrWide = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        check("wait_req", 32'(MemReq), 32'd1);
        check("wait_addr", 32'(MemAddr), exp_pc);
        repeat (delay) step();
        check("wait_req_held", 32'(MemReq), 32'd1);

        misalign = taken && tgt[0];
        sel = taken ? 2'd0 : (wide ? 2'd2 : 2'd1);
        nxt = taken ? 32'(tgt) : ((exp_pc + (wide ? 32'd4 : 32'd2)) & 32'h1FFFF);
        if (!misalign && !halt) sb_q.push_back(nxt);

        MemAck = 1'b1; InstrWide = wide; BranchTaken = taken; BranchTarget = tgt; Halt = halt;
        step();
        MemAck = 1'b0; InstrWide = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        check("adv_sel", 32'(Selection), 32'(sel));
        check("adv_req_low", 32'(MemReq), 32'd0);
        check("adv_pc_old", 32'(PC), exp_pc);
        step();
        Halt = 1'b0;
        if (misalign) begin
            check("misalign_fault", 32'(Fault), 32'd1);
            check("misalign_req", 32'(MemReq), 32'd0);
            check("misalign_pc", 32'(PC), exp_pc);
            check("misalign_running", 32'(Running), 32'd0);
        end else begin
            exp_pc = nxt;
            check("next_pc", 32'(PC), exp_pc);
            if (halt) begin
                check("halt_req", 32'(MemReq), 32'd0);
                check("halt_running", 32'(Running), 32'd0);
            end else begin
                check("refetch_latency", 32'(MemReq), 32'd1);
            end
        end
    endtask

    initial begin
        // Reset values and no fetch without Start.
        step();
        step();
        check("rst_req", 32'(MemReq), 32'd0);
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_sel", 32'(Selection), 32'd1);
        check("rst_running", 32'(Running), 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        ResetN = 1'b1;
        Halt = 1'b1;
        MemAck = 1'b1;
        repeat (3) step();
        Halt = 1'b0;
        MemAck = 1'b0;
        check("idle_no_req", 32'(MemReq), 32'd0);
        check("idle_pc", 32'(PC), 32'd0);

        // Narrow, branch, wrap-around and ack-at-timeout instructions.
        start_fetch();
        do_instr(3, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b0);
        do_instr(0, 1'b0, 1'b1, 17'h1FFFC, 1'b0, 1'b0);
        do_instr(1, 1'b1, 1'b0, 17'h00000, 1'b0, 1'b1);
        do_instr(2, 1'b1, 1'b0, 17'h00000, 1'b0, 1'b0);
        do_instr(0, 1'b0, 1'b1, 17'h1FFFE, 1'b0, 1'b0);
        do_instr(0, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b0);
        do_instr(14, 1'b0, 1'b1, 17'h00100, 1'b0, 1'b0);

        // Halt returns to IDLE; Start resumes at the advanced PC.
        do_instr(0, 1'b0, 1'b0, 17'h00000, 1'b1, 1'b0);
        repeat (3) step();
        check("halted_req", 32'(MemReq), 32'd0);
        check("halted_pc", 32'(PC), 32'h102);
        start_fetch();
        do_instr(5, 1'b1, 1'b0, 17'h00000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        step();
        step();
        check("midwait_req", 32'(MemReq), 32'd1);
        ResetN = 1'b0;
        #1;
        check("async_req", 32'(MemReq), 32'd0);
        check("async_pc", 32'(PC), 32'd0);
        check("async_fault", 32'(Fault), 32'd0);
        check("async_sel", 32'(Selection), 32'd1);
        check("async_running", 32'(Running), 32'd0);
        step();
        ResetN = 1'b1;
        exp_pc = 0;
        sb_q.delete();
        repeat (3) step();
        check("post_rst_no_req", 32'(MemReq), 32'd0);

        // Timeout: 15 silent WAIT cycles fault; Start and MemAck are then ignored.
        start_fetch();
        step();
        repeat (14) step();
        check("to_wait15_req", 32'(MemReq), 32'd1);
        check("to_wait15_fault", 32'(Fault), 32'd0);
        step();
        check("to_fault", 32'(Fault), 32'd1);
        check("to_req", 32'(MemReq), 32'd0);
        check("to_running", 32'(Running), 32'd0);
        Start = 1'b1;
        MemAck = 1'b1;
        repeat (2) step();
        Start = 1'b0;
        MemAck = 1'b0;
        step();
        check("to_sticky_fault", 32'(Fault), 32'd1);
        check("to_sticky_req", 32'(MemReq), 32'd0);
        check("to_pc", 32'(PC), 32'd0);

        // Odd branch target faults from ADVANCE with the PC left alone.
        do_reset();
        step();
        check("clear_fault", 32'(Fault), 32'd0);
        start_fetch();
        do_instr(0, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b0);
        do_instr(1, 1'b0, 1'b1, 17'h00101, 1'b0, 1'b0);
        repeat (3) step();
        check("odd_sticky_fault", 32'(Fault), 32'd1);
        check("odd_pc_frozen", 32'(PC), 32'd2);
        check("odd_req", 32'(MemReq), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
